rf_32: RTL and testbench



---
 rtl/rf_32.sv | 68 ++++++
 tb/tb_rf_32.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/rf_32.sv
// rtl/rf_32.sv - 32x32 register file, two read ports and one write port, launched by a start rise.
// Outputs are registered; a read of the address being written returns the new data.
module rf_32 (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [4:0]  read_addr_s,
    input  logic [4:0]  read_addr_t,
    input  logic [4:0]  write_addr,
    input  logic [31:0] write_data,
    input  logic        write_enabled,
    output logic        finish,
    output logic [31:0] outA,
    output logic [31:0] outB
);

    logic [31:0] register_file [0:31];
    logic        start_q;
    logic        finish_q;
    logic [31:0] outa_q;
    logic [31:0] outb_q;
    logic        launch_d;
    logic [31:0] outa_d;
    logic [31:0] outb_d;

    always_comb begin
        launch_d = start && !start_q;
        outa_d   = register_file[read_addr_s];
        outb_d   = register_file[read_addr_t];
        // Write-first bypass so a same-launch read sees the value being stored.
        if (write_enabled && (read_addr_s == write_addr)) begin
            outa_d = write_data;
        end
        if (write_enabled && (read_addr_t == write_addr)) begin
            outb_d = write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                register_file[i] <= '0;
            end
            outa_q   <= '0;
            outb_q   <= '0;
            finish_q <= 1'b0;
            // Seeded high so a start held through reset must fall and rise again.
            start_q  <= 1'b1;
        end else begin
            start_q <= start;
            if (launch_d) begin
                if (write_enabled) begin
                    register_file[write_addr] <= write_data;
                end
                outa_q   <= outa_d;
                outb_q   <= outb_d;
                finish_q <= 1'b1;
            end else if (!start) begin
                finish_q <= 1'b0;
            end
        end
    end

    assign finish = finish_q;
    assign outA   = outa_q;
    assign outB   = outb_q;

endmodule

// File: tb/tb_rf_32.sv
// tb/tb_rf_32.sv - directed self-checking bench for rf_32.
module tb_rf_32;

    logic        clk;
    logic        reset;
    logic        start;
    logic [4:0]  read_addr_s;
    logic [4:0]  read_addr_t;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic        write_enabled;
    logic        finish;
    logic [31:0] outA;
    logic [31:0] outB;

    int checks;
    int failures;

    rf_32 dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .read_addr_s  (read_addr_s),
        .read_addr_t  (read_addr_t),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .write_enabled(write_enabled),
        .finish       (finish),
        .outA         (outA),
        .outB         (outB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] sweep_val(input int i);
        if (i == 0 || i == 31) return 32'hDEADBEEF;
        if (i == 1) return 32'h0;
        if (i <= 16) return 32'h11111111 * (i - 1);
        return 32'(i - 16);
    endfunction

    // One full operation: rise start, check finish, drop start, check finish clears.
    task automatic do_op(input logic [4:0] s, input logic [4:0] t, input logic we,
                         input logic [4:0] wa, input logic [31:0] wd);
        read_addr_s   = s;
        read_addr_t   = t;
        write_enabled = we;
        write_addr    = wa;
        write_data    = wd;
        start         = 1'b1;
        tick();
        chk("finish_high", {31'b0, finish}, 32'd1);
        start = 1'b0;
        tick();
        chk("finish_low", {31'b0, finish}, 32'd0);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        reset         = 1'b1;
        start         = 1'b0;
        read_addr_s   = '0;
        read_addr_t   = '0;
        write_addr    = '0;
        write_data    = '0;
        write_enabled = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("reset_finish", {31'b0, finish}, 32'd0);
        chk("reset_outA", outA, 32'h0);
        chk("reset_outB", outB, 32'h0);

        for (int i = 0; i < 32; i += 2) begin
            do_op(5'(i), 5'(i + 1), 1'b0, 5'd0, 32'hFFFFFFFF);
            chk("zero_outA", outA, 32'h0);
            chk("zero_outB", outB, 32'h0);
        end

        for (int i = 0; i < 32; i++) begin
            do_op(5'd0, 5'd0, 1'b1, 5'(i), sweep_val(i));
        end
        for (int i = 0; i < 32; i++) begin
            chk("sweep_mem", dut.register_file[i], sweep_val(i));
        end

        for (int i = 0; i < 32; i++) begin
            do_op(5'(i), 5'(31 - i), 1'b0, 5'(i), 32'h0BAD0BAD);
            chk("read_s", outA, sweep_val(i));
            chk("read_t_rev", outB, sweep_val(31 - i));
        end
        for (int i = 0; i < 32; i++) begin
            do_op(5'd9, 5'(i), 1'b0, 5'd0, 32'h0);
            chk("read_t", outB, sweep_val(i));
            chk("read_s9", outA, 32'h88888888);
        end
        chk("mem_unchanged", dut.register_file[31], 32'hDEADBEEF);

        do_op(5'd5, 5'd9, 1'b1, 5'd5, 32'h12345678);
        chk("bypass_outA", outA, 32'h12345678);
        chk("bypass_outB_other", outB, 32'h88888888);
        chk("bypass_mem", dut.register_file[5], 32'h12345678);
        do_op(5'd0, 5'd5, 1'b1, 5'd5, 32'h87654321);
        chk("bypass_outB", outB, 32'h87654321);
        chk("bypass_outA_other", outA, 32'hDEADBEEF);
        read_addr_s   = 5'd2;
        write_addr    = 5'd3;
        write_enabled = 1'b1;
        tick();
        chk("idle_hold_outA", outA, 32'hDEADBEEF);
        chk("idle_no_write", dut.register_file[3], 32'h22222222);

        write_enabled = 1'b1;
        write_addr    = 5'd7;
        read_addr_s   = 5'd7;
        write_data    = 32'hA0000001;
        start         = 1'b1;
        tick();
        chk("hold_first_finish", {31'b0, finish}, 32'd1);
        chk("hold_first_mem", dut.register_file[7], 32'hA0000001);
        for (int k = 2; k <= 5; k++) begin
            write_data = 32'hA0000000 + 32'(k);
            tick();
            chk("hold_finish", {31'b0, finish}, 32'd1);
            chk("hold_mem", dut.register_file[7], 32'hA0000001);
            chk("hold_outA", outA, 32'hA0000001);
        end
        start = 1'b0;
        tick();
        chk("hold_drop_finish", {31'b0, finish}, 32'd0);
        chk("hold_drop_mem", dut.register_file[7], 32'hA0000001);

        read_addr_s   = 5'd9;
        read_addr_t   = 5'd31;
        write_enabled = 1'b1;
        write_addr    = 5'd3;
        write_data    = 32'h55555555;
        start         = 1'b1;
        tick();
        chk("pre_reset_finish", {31'b0, finish}, 32'd1);
        chk("pre_reset_mem", dut.register_file[3], 32'h55555555);
        reset = 1'b1;
        tick();
        chk("midop_reset_finish", {31'b0, finish}, 32'd0);
        chk("midop_reset_outA", outA, 32'h0);
        chk("midop_reset_outB", outB, 32'h0);
        for (int i = 0; i < 32; i++) begin
            chk("midop_reset_mem", dut.register_file[i], 32'h0);
        end
        reset         = 1'b0;
        write_addr    = 5'd4;
        write_data    = 32'hCAFEF00D;
        read_addr_s   = 5'd4;
        tick();
        chk("held_start_no_launch_finish", {31'b0, finish}, 32'd0);
        chk("held_start_no_launch_mem", dut.register_file[4], 32'h0);
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        chk("relaunch_finish", {31'b0, finish}, 32'd1);
        chk("relaunch_mem", dut.register_file[4], 32'hCAFEF00D);
        chk("relaunch_outA", outA, 32'hCAFEF00D);
        start = 1'b0;
        tick();

        write_addr = 5'd2;
        write_data = 32'h00000001;
        start      = 1'b1;
        reset      = 1'b1;
        tick();
        chk("reset_priority_mem", dut.register_file[2], 32'h0);
        chk("reset_priority_finish", {31'b0, finish}, 32'd0);
        reset = 1'b0;
        start = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
